// File: rtl/asteroid_spawner_if.sv
// asteroid_spawner_if: game-side control/status bundle of the asteroid spawner.
interface asteroid_spawner_if;
   logic       run;
   logic [7:0] a_hit;
   logic       ship_hit;
   logic [7:0] a_state;
   logic       spawn_valid;
   logic [2:0] spawn_slot;
   logic [3:0] level;
   logic [7:0] kills;
   modport master (output run, a_hit, ship_hit, input a_state, spawn_valid, spawn_slot, level, kills);
   modport slave (input run, a_hit, ship_hit, output a_state, spawn_valid, spawn_slot, level, kills);
endinterface

// File: rtl/asteroid_spawner.sv
// asteroid_spawner: picks which asteroid slot to activate and when, retires hit asteroids,
// applies respawn cooldowns and tracks kills and difficulty level; one clock edge is one game tick.
module asteroid_spawner #(
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          BASE_INTERVAL   = 60,
   parameter int          STEP            = 5,
   parameter int          MIN_INTERVAL    = 10,
   parameter int          COOLDOWN        = 30,
   parameter int          KILLS_PER_LEVEL = 8,
   parameter int          MAX_LEVEL       = 9
) (
   input logic              clock,
   input logic              reset,
   asteroid_spawner_if.slave bus
);
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   typedef enum logic [1:0] {IDLE, PLAY, CLEAR} state_t;
   state_t      state, state_n;
   logic [15:0] lfsr, lfsr_n;
   logic [7:0]  act, act_n;
   logic        sv, sv_n;
   logic [2:0]  slot, slot_n;
   logic [3:0]  lvl, lvl_n;
   logic [7:0]  kills_q, kills_n;
   logic [7:0]  kil, kil_n;
   logic [7:0]  icnt, icnt_n;
   logic [7:0]  clr, clr_n;
   logic [7:0]  cd [8];
   logic [7:0]  cd_n [8];
   logic [7:0]  valid, elig;
   logic [2:0]  pick;
   logic        found, spawn, up;
   logic [3:0]  n;
   logic [8:0]  ksum, kil_sum;
   logic [15:0] red;
   logic [7:0]  interval;
   assign bus.a_state     = act;
   assign bus.spawn_valid = sv;
   assign bus.spawn_slot  = slot;
   assign bus.level       = lvl;
   assign bus.kills       = kills_q;
   assign red      = 16'(STEP) * 16'(lvl);
   assign interval = (red + 16'(MIN_INTERVAL) >= 16'(BASE_INTERVAL)) ? 8'(MIN_INTERVAL) : 8'(16'(BASE_INTERVAL) - red);
   assign valid    = bus.a_hit & act;
   assign n        = 4'($countones(valid));
   assign ksum     = {1'b0, kills_q} + 9'(n);
   assign kil_sum  = {1'b0, kil} + 9'(n);
   assign up       = kil_sum >= 9'(KILLS_PER_LEVEL);
   always_comb begin
      for (int i = 0; i < 8; i++) elig[i] = !act[i] && cd[i] == 8'd0 && !bus.a_hit[i];
   end
   // Walk downward so the last match written is the first eligible slot ascending from lfsr[2:0].
   always_comb begin
      pick = 3'd0;
      for (int k = 7; k >= 0; k--) if (elig[3'(lfsr[2:0] + 3'(k))]) pick = 3'(lfsr[2:0] + 3'(k));
   end
   assign found = |elig;
   assign spawn = icnt == 8'd0 && found;
   always_comb begin
      state_n = state;
      lfsr_n  = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      act_n   = act;
      sv_n    = 1'b0;
      slot_n  = slot;
      lvl_n   = lvl;
      kills_n = kills_q;
      kil_n   = kil;
      icnt_n  = icnt;
      clr_n   = clr;
      cd_n    = cd;
      case (state)
         IDLE: begin
            if (bus.run) begin
               state_n = PLAY;
               icnt_n  = interval;
            end
         end
         PLAY: begin
            if (bus.ship_hit) begin
               state_n = CLEAR;
               act_n   = 8'd0;
               lvl_n   = 4'd0;
               kil_n   = 8'd0;
               clr_n   = 8'(COOLDOWN);
               for (int i = 0; i < 8; i++) cd_n[i] = 8'd0;
            end else if (!bus.run) begin
               state_n = IDLE;
               act_n   = 8'd0;
            end else begin
               for (int i = 0; i < 8; i++) cd_n[i] = valid[i] ? 8'(COOLDOWN) : (cd[i] != 8'd0 ? cd[i] - 8'd1 : 8'd0);
               act_n   = (act & ~valid) | (spawn ? 8'd1 << pick : 8'd0);
               sv_n    = spawn;
               slot_n  = spawn ? pick : slot;
               icnt_n  = icnt != 8'd0 ? icnt - 8'd1 : (found ? interval : 8'd0);
               kills_n = ksum[8] ? 8'hFF : ksum[7:0];
               kil_n   = up ? 8'(kil_sum - 9'(KILLS_PER_LEVEL)) : kil_sum[7:0];
               lvl_n   = (up && lvl != 4'(MAX_LEVEL)) ? lvl + 4'd1 : lvl;
            end
         end
         CLEAR: begin
            if (clr != 8'd0) clr_n = clr - 8'd1;
            else begin
               state_n = bus.run ? PLAY : IDLE;
               icnt_n  = interval;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         lfsr    <= SEED;
         act     <= 8'd0;
         sv      <= 1'b0;
         slot    <= 3'd0;
         lvl     <= 4'd0;
         kills_q <= 8'd0;
         kil     <= 8'd0;
         icnt    <= 8'd0;
         clr     <= 8'd0;
         for (int i = 0; i < 8; i++) cd[i] <= 8'd0;
      end else begin
         state   <= state_n;
         lfsr    <= lfsr_n;
         act     <= act_n;
         sv      <= sv_n;
         slot    <= slot_n;
         lvl     <= lvl_n;
         kills_q <= kills_n;
         kil     <= kil_n;
         icnt    <= icnt_n;
         clr     <= clr_n;
         for (int i = 0; i < 8; i++) cd[i] <= cd_n[i];
      end
   end
endmodule

// File: tb/tb_asteroid_spawner.sv
// tb_asteroid_spawner: directed phase table, hand sequences and random play checked against a game-rule model.
module tb_asteroid_spawner;
   localparam int BASE = 60, STEP = 5, MINI = 10, CD = 30, KPL = 8, MAXL = 9;
   logic clock = 1'b0, reset = 1'b1, clk_en = 1'b1;
   asteroid_spawner_if bus();
   asteroid_spawner dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = clk_en ? ~clock : clock;
   int vectors = 0, miscompares = 0;
   int m_mode, m_lfsr, m_wait, m_clr, m_level, m_kills, m_kil, m_sv, m_slot;
   int m_act [8];
   int m_cd [8];
   int spawns;
   typedef struct {
      bit run; logic [7:0] a_hit; bit ship_hit; int ticks;
      int exp_spawns; int exp_active; int exp_kills; int exp_level;
   } vec_t;
   vec_t tbl [$];
   function automatic int iv(int lv);
      int v = BASE - STEP * lv;
      return v < MINI ? MINI : v;
   endfunction
   task automatic model_reset();
      m_mode = 0; m_lfsr = 'hACE1; m_wait = 0; m_clr = 0; m_level = 0; m_kills = 0; m_kil = 0; m_sv = 0; m_slot = 0;
      for (int i = 0; i < 8; i++) begin m_act[i] = 0; m_cd[i] = 0; end
   endtask
   task automatic model_step(input bit r, input logic [7:0] ah, input bit sh);
      int nl, hits, pick, s;
      nl = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
      m_sv = 0;
      if (m_mode == 0) begin
         if (r) begin m_mode = 1; m_wait = iv(m_level); end
      end else if (m_mode == 2) begin
         if (m_clr > 0) m_clr--;
         else begin m_mode = r ? 1 : 0; m_wait = iv(m_level); end
      end else if (sh) begin
         m_mode = 2; m_level = 0; m_kil = 0; m_clr = CD;
         for (int i = 0; i < 8; i++) begin m_act[i] = 0; m_cd[i] = 0; end
      end else if (!r) begin
         m_mode = 0;
         for (int i = 0; i < 8; i++) m_act[i] = 0;
      end else begin
         pick = -1;
         if (m_wait == 0)
            for (int k = 0; k < 8; k++) begin
               s = (m_lfsr % 8 + k) % 8;
               if (pick < 0 && m_act[s] == 0 && m_cd[s] == 0 && !ah[s]) pick = s;
            end
         hits = 0;
         for (int i = 0; i < 8; i++)
            if (ah[i] && m_act[i] == 1) begin hits++; m_act[i] = 0; m_cd[i] = CD; end
            else if (m_cd[i] > 0) m_cd[i]--;
         if (m_wait > 0) m_wait--;
         else if (pick >= 0) begin m_act[pick] = 1; m_sv = 1; m_slot = pick; m_wait = iv(m_level); end
         m_kills = (m_kills + hits > 255) ? 255 : m_kills + hits;
         m_kil += hits;
         if (m_kil >= KPL) begin m_kil -= KPL; if (m_level < MAXL) m_level++; end
      end
      m_lfsr = nl;
   endtask
   task automatic check_model(input string name);
      logic [7:0] ea;
      for (int i = 0; i < 8; i++) ea[i] = m_act[i][0];
      vectors++;
      if (bus.a_state !== ea || bus.spawn_valid !== m_sv[0] || bus.spawn_slot !== 3'(m_slot) ||
          bus.level !== 4'(m_level) || bus.kills !== 8'(m_kills)) begin
         miscompares++;
         $display("FAIL %s t=%0t: got a_state=%h sv=%b slot=%0d level=%0d kills=%0d, expected a_state=%h sv=%0d slot=%0d level=%0d kills=%0d",
                  name, $time, bus.a_state, bus.spawn_valid, bus.spawn_slot, bus.level, bus.kills,
                  ea, m_sv, m_slot, m_level, m_kills);
      end
   endtask
   task automatic check_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask
   task automatic tick(input bit r, input logic [7:0] ah, input bit sh);
      bus.run = r; bus.a_hit = ah; bus.ship_hit = sh;
      @(posedge clock);
      model_step(r, ah, sh);
      #1;
      check_model("tick");
      if (bus.spawn_valid) spawns++;
      @(negedge clock);
   endtask
   initial begin
      int guard, gap;
      logic [7:0] ah;
      bus.run = 0; bus.a_hit = 0; bus.ship_hit = 0;
      model_reset();
      tbl.push_back('{0, 8'h00, 0, 100, 0, 0, 0, 0});
      tbl.push_back('{1, 8'h00, 0, 61,  0, 0, 0, 0});
      tbl.push_back('{1, 8'h00, 0, 1,   1, 1, 0, 0});
      tbl.push_back('{1, 8'h00, 0, 366, 6, 7, 0, 0});
      tbl.push_back('{1, 8'h00, 0, 61,  1, 8, 0, 0});
      tbl.push_back('{1, 8'h00, 0, 80,  0, 8, 0, 0});
      tbl.push_back('{1, 8'hFF, 0, 1,   0, 0, 8, 1});
      tbl.push_back('{1, 8'h00, 0, 30,  0, 0, 8, 1});
      tbl.push_back('{1, 8'h00, 0, 1,   1, 1, 8, 1});
      tbl.push_back('{1, 8'h00, 0, 56,  1, 2, 8, 1});
      tbl.push_back('{1, 8'h04, 1, 1,   0, 0, 8, 0});
      tbl.push_back('{1, 8'h00, 0, 31,  0, 0, 8, 0});
      tbl.push_back('{1, 8'h00, 0, 61,  1, 1, 8, 0});
      tbl.push_back('{0, 8'h00, 0, 1,   0, 0, 8, 0});
      tbl.push_back('{0, 8'hFF, 1, 20,  0, 0, 8, 0});
      repeat (3) @(negedge clock);
      check_model("reset_state");
      reset = 1'b0;
      foreach (tbl[v]) begin
         spawns = 0;
         repeat (tbl[v].ticks) tick(tbl[v].run, tbl[v].a_hit, tbl[v].ship_hit);
         check_int($sformatf("phase%0d_spawns", v), spawns, tbl[v].exp_spawns);
         check_int($sformatf("phase%0d_active", v), $countones(bus.a_state), tbl[v].exp_active);
         check_int($sformatf("phase%0d_kills", v), int'(bus.kills), tbl[v].exp_kills);
         check_int($sformatf("phase%0d_level", v), int'(bus.level), tbl[v].exp_level);
      end
      // four live asteroids, then every slot flagged as hit in one tick
      repeat (245) tick(1, 8'h00, 0);
      check_int("four_active", $countones(bus.a_state), 4);
      tick(1, 8'hFF, 0);
      check_int("partial_hit_kills", int'(bus.kills), 12);
      check_int("partial_hit_state", int'(bus.a_state), 0);
      repeat (100) tick(1, 8'h00, 0);
      check_int("active_before_reset", int'(bus.a_state != 0), 1);
      // asynchronous reset while the clock is stopped
      clk_en = 1'b0;
      #7 reset = 1'b1;
      #1;
      model_reset();
      check_model("async_reset");
      bus.run = 0; bus.a_hit = 0; bus.ship_hit = 0;
      #8 reset = 1'b0;
      #1 clk_en = 1'b1;
      spawns = 0;
      repeat (100) tick(0, 8'h00, 0);
      check_int("idle_spawns", spawns, 0);
      check_int("idle_state", int'(bus.a_state), 0);
      // kill every asteroid right after it spawns until the level saturates
      guard = 0; ah = 0;
      while (m_level < MAXL && guard < 8000) begin
         tick(1, ah, 0);
         ah = m_sv ? 8'(1 << m_slot) : 8'h00;
         guard++;
      end
      check_int("level_reached_in_budget", int'(guard < 8000), 1);
      check_int("level_sat", int'(bus.level), 9);
      check_int("kills_at_sat", int'(bus.kills), 72);
      guard = 0;
      do begin tick(1, 8'h00, 0); guard++; end while (!bus.spawn_valid && guard < 100);
      gap = 0;
      do begin tick(1, 8'h00, 0); gap++; end while (!bus.spawn_valid && gap < 100);
      check_int("gap_at_max_level", gap, iv(MAXL) + 1);
      repeat (3000) begin
         bit r, sh;
         logic [7:0] live;
         for (int i = 0; i < 8; i++) live[i] = m_act[i][0];
         r  = $urandom_range(0, 99) < 97;
         sh = $urandom_range(0, 499) == 0;
         ah = ($urandom_range(0, 2) == 0) ? (8'($urandom) & (live | 8'($urandom))) : 8'h00;
         tick(r, ah, sh);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
